// File: rtl/seg_scan_if.sv
// Bundle between the CPU-side source of a display word and the scanner.
// The master drives the word, load strobe and enable; the slave (seg_scan)
// returns the selected nibble, the anode enables and the frame pulse.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic [31:0]       value;
    logic              load;
    logic              en;
    logic [3:0]        num;
    logic [DIGITS-1:0] an;
    logic              frame;

    modport master (
        output value,
        output load,
        output en,
        input  num,
        input  an,
        input  frame
    );

    modport slave (
        input  value,
        input  load,
        input  en,
        output num,
        output an,
        output frame
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for an 8-digit common-anode seven-segment display.
// A loaded word waits in a pending register and is copied to the displayed
// register only at a frame boundary, so a frame never mixes two words.
// num/an are decoded from registered state (plus en) and feed the decoder.
module seg_scan #(
    parameter int TICK_DIV = 100000,
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOTS = 1 << IDX_W;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0] div_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      pend_r;
    logic [31:0]      disp_r;
    logic             frame_r;

    logic             tick_s;
    logic             wrap_s;
    logic [SLOTS-1:0] zero_tail_s;
    logic             blank_s;
    logic [SLOTS-1:0] an_full_s;

    // Nibble i of a word; index is widened so slots past DIGITS stay in range.
    function automatic logic [3:0] nibble_at(input logic [31:0] word,
                                             input logic [IDX_W-1:0] i);
        return word[{i, 2'b00} +: 4];
    endfunction

    assign tick_s = (div_r == DIV_LAST);
    assign wrap_s = tick_s && (idx_r == IDX_LAST);

    // Free-running digit-time divider; keeps running while the display is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1'b1);
        end
    end

    // Digit index advances once per tick and wraps after the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= '0;
        end else if (wrap_s) begin
            idx_r <= '0;
        end else if (tick_s) begin
            idx_r <= idx_r + IDX_W'(1'b1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Pending word: last load wins; displayed word takes the pre-edge pending
    // value only at a wrap, so a coincident load shows up one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 32'h0000_0000;
            disp_r <= 32'h0000_0000;
        end else begin
            if (bus.load) begin
                pend_r <= bus.value;
            end else begin
                pend_r <= pend_r;
            end
            if (wrap_s) begin
                disp_r <= pend_r;
            end else begin
                disp_r <= disp_r;
            end
        end
    end

    // One-cycle frame pulse in the first cycle of each new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r <= 1'b0;
        end else begin
            frame_r <= wrap_s;
        end
    end

    // zero_tail_s[i] is set when nibbles i..DIGITS-1 of the displayed word are all zero.
    always_comb begin
        logic acc;
        zero_tail_s = '1;
        acc         = 1'b1;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            acc            = acc & ((i >= DIGITS) || (disp_r[4*i +: 4] == 4'h0));
            zero_tail_s[i] = acc;
        end
    end

    assign blank_s = (BLANK_LZ != 0) && (idx_r != '0) && zero_tail_s[idx_r];

    // Active-low anode decode: one digit low when enabled and not blanked.
    always_comb begin
        an_full_s = '1;
        if (bus.en && !blank_s) begin
            an_full_s[idx_r] = 1'b0;
        end else begin
            an_full_s = '1;
        end
    end

    assign bus.an    = an_full_s[DIGITS-1:0];
    assign bus.num   = nibble_at(disp_r, idx_r);
    assign bus.frame = frame_r;
endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with TICK_DIV=4, DIGITS=8, BLANK_LZ=1.
// Expected per-cycle {num, an, frame} for a whole frame are pushed into a
// scoreboard when a word is loaded and popped as the frame is scanned.
module tb_seg_scan;
    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 8;
    localparam int FRAME_CY = TICK_DIV * DIGITS;

    typedef struct packed {
        logic [3:0] num;
        logic [7:0] an;
        logic       frame;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        int          lit_digits;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(DIGITS)) bus();

    seg_scan #(
        .TICK_DIV(TICK_DIV),
        .DIGITS  (DIGITS),
        .BLANK_LZ(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Expected anodes: every digit up to the highest non-zero nibble is lit.
    function automatic logic [7:0] model_an(input logic [31:0] w, input int d);
        int top;
        logic [7:0] one;
        top = 0;
        one = 8'h01;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] != 4'h0) top = i;
        end
        return (d <= top) ? ~(one << d) : 8'hFF;
    endfunction

    function automatic logic [3:0] model_num(input logic [31:0] w, input int d);
        return w[4*d +: 4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] w);
        for (int c = 0; c < FRAME_CY; c++) begin
            sb.push_back('{num: model_num(w, c / TICK_DIV),
                           an: model_an(w, c / TICK_DIV),
                           frame: (c == 0)});
        end
    endtask

    // Step until the frame pulse is visible, bounded.
    task automatic wait_wrap();
        int n;
        n = 0;
        while (bus.frame !== 1'b1 && n < 3 * FRAME_CY) begin
            step();
            n++;
        end
        if (bus.frame !== 1'b1) check("wrap_timeout", 32'(bus.frame), 32'd1);
    endtask

    // Compare one whole frame against the scoreboard; ends on its last cycle.
    task automatic run_frame(output int lit);
        exp_t e;
        wait_wrap();
        lit = 0;
        for (int c = 0; c < FRAME_CY; c++) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            check("num",   32'(bus.num),   32'(e.num));
            check("an",    32'(bus.an),    32'(e.an));
            check("frame", 32'(bus.frame), 32'(e.frame));
            if (c % TICK_DIV == 0 && bus.an != 8'hFF) lit++;
            if (c < FRAME_CY - 1) step();
        end
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] cur;
        int          lit;
        int          n;

        vecs[0] = '{32'h1234_5678, 8};
        vecs[1] = '{32'h0000_0305, 3};
        vecs[2] = '{32'h0000_0000, 1};
        vecs[3] = '{32'hF000_000A, 8};
        vecs[4] = '{32'h000B_0000, 5};

        rst       = 1'b1;
        bus.value = 32'h0;
        bus.load  = 1'b0;
        bus.en    = 1'b1;

        // Reset state
        step();
        check("rst_frame_held", 32'(bus.frame), 32'd0);
        step();
        rst = 1'b0;
        check("rst_an",    32'(bus.an),    32'h0000_00FE);
        check("rst_num",   32'(bus.num),   32'd0);
        check("rst_frame", 32'(bus.frame), 32'd0);
        repeat (3) step();
        check("div_hold_an", 32'(bus.an), 32'h0000_00FE);
        step();
        check("idx1_blank_an", 32'(bus.an), 32'h0000_00FF);
        check("idx1_num",      32'(bus.num), 32'd0);
        cur = 32'h0;

        // Table-driven: load mid-frame (digit 2), no tearing, then full next frame.
        for (int v = 0; v < 5; v++) begin
            wait_wrap();
            repeat (2 * TICK_DIV) step();
            bus.value = vecs[v].value;
            bus.load  = 1'b1;
            step();
            bus.load  = 1'b0;
            bus.value = 32'hDEAD_BEEF;
            check("no_tear_num", 32'(bus.num), 32'(model_num(cur, 2)));
            check("no_tear_an",  32'(bus.an),  32'(model_an(cur, 2)));
            push_frame(vecs[v].value);
            step();
            run_frame(lit);
            check("lit_count", 32'(lit), 32'(vecs[v].lit_digits));
            cur = vecs[v].value;
        end

        // Load coinciding with the wrap tick: old pending shows first.
        wait_wrap();
        repeat (2 * TICK_DIV) step();
        bus.value = 32'hAAAA_AAAA;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        repeat (FRAME_CY - 2 * TICK_DIV - 2) step();
        check("pre_wrap_an", 32'(bus.an), 32'(model_an(cur, DIGITS - 1)));
        bus.value = 32'h5555_5555;
        bus.load  = 1'b1;
        push_frame(32'hAAAA_AAAA);
        push_frame(32'h5555_5555);
        step();
        bus.load = 1'b0;
        run_frame(lit);
        step();
        run_frame(lit);
        cur = 32'h5555_5555;

        // Display disabled for 10 cycles mid-scan; index keeps moving.
        wait_wrap();
        repeat (5) step();
        bus.en = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            check("en0_an",  32'(bus.an),  32'h0000_00FF);
            check("en0_num", 32'(bus.num), 32'(model_num(cur, (5 + k) / TICK_DIV)));
        end
        step();
        bus.en = 1'b1;
        #1;
        check("en1_an",  32'(bus.an),  32'(model_an(cur, 3)));
        check("en1_num", 32'(bus.num), 32'(model_num(cur, 3)));

        // Reset mid-frame with a non-zero pending word.
        bus.value = 32'h0000_0ABC;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (5) step();
        check("pre_rst_an", 32'(bus.an), 32'(model_an(cur, 5)));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_an",    32'(bus.an),    32'h0000_00FE);
        check("mid_rst_num",   32'(bus.num),   32'd0);
        check("mid_rst_frame", 32'(bus.frame), 32'd0);
        n = 0;
        for (int i = 1; i <= 2 * FRAME_CY; i++) begin
            step();
            if (i == TICK_DIV) check("post_rst_idx1_an", 32'(bus.an), 32'h0000_00FF);
            if (bus.frame === 1'b1) begin
                n = i;
                break;
            end
        end
        check("post_rst_wrap_dist", 32'(n), 32'(FRAME_CY));
        check("post_rst_pend_num",  32'(bus.num), 32'd0);
        check("post_rst_pend_an",   32'(bus.an),  32'h0000_00FE);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
